// File: rtl/lpif_ll_pkg.sv
// Logic-link word layout and shared types for the x2 asymmetric-1 full-rate LPIF-over-AIB link.
// The master transmitter and the slave-side unpacker both import this package.
package lpif_ll_pkg;

  localparam int unsigned LL_WORD_W     = 75;

  localparam int unsigned STATE_LSB     = 0;
  localparam int unsigned STATE_W       = 4;
  localparam int unsigned PROTID_LSB    = 4;
  localparam int unsigned PROTID_W      = 2;
  localparam int unsigned DATA_LSB      = 6;
  localparam int unsigned DATA_W        = 64;
  localparam int unsigned DVALID_LSB    = 70;
  localparam int unsigned CRC_LSB       = 71;
  localparam int unsigned CRC_W         = 2;
  localparam int unsigned CRC_VALID_LSB = 73;
  localparam int unsigned VALID_LSB     = 74;

  // Declared MSB first so the packed struct matches the bit offsets above.
  typedef struct packed {
    logic                valid;
    logic                crc_valid;
    logic [CRC_W-1:0]    crc;
    logic                dvalid;
    logic [DATA_W-1:0]   data;
    logic [PROTID_W-1:0] protid;
    logic [STATE_W-1:0]  state;
  } lpif_ll_word_t;

  typedef enum logic [1:0] {
    OFFLINE = 2'd0,
    ACTIVE  = 2'd1,
    FLUSH   = 2'd2
  } ll_tx_state_e;

endpackage

// File: rtl/lpif_ll_dstrm_tx_master_if.sv
// Downstream LPIF channel from the master adapter into the logic-link transmitter.
interface lpif_ll_dstrm_tx_master_if;

  logic [3:0]  dstrm_state;
  logic [1:0]  dstrm_protid;
  logic [63:0] dstrm_data;
  logic        dstrm_dvalid;
  logic [1:0]  dstrm_crc;
  logic        dstrm_crc_valid;
  logic        dstrm_valid;
  logic        dstrm_ready;

  modport master (
    output dstrm_state, dstrm_protid, dstrm_data, dstrm_dvalid,
           dstrm_crc, dstrm_crc_valid, dstrm_valid,
    input  dstrm_ready
  );

  modport slave (
    input  dstrm_state, dstrm_protid, dstrm_data, dstrm_dvalid,
           dstrm_crc, dstrm_crc_valid, dstrm_valid,
    output dstrm_ready
  );

endinterface

// File: rtl/lpif_ll_sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers and a synchronous flush.
module lpif_ll_sync_fifo #(
  parameter int unsigned WIDTH = 75,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                    (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign do_push  = push && (!full || pop) && !flush;
  assign do_pop   = pop && !empty && !flush;
  assign pop_data = mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PTR_W-1:0]] <= push_data;
  end

endmodule

// File: rtl/lpif_ll_dstrm_tx_master.sv
// Master-end logic-link transmitter: packs the downstream LPIF channel into 75-bit words,
// buffers them, and releases them toward the link under far-end credit flow control.
module lpif_ll_dstrm_tx_master
  import lpif_ll_pkg::*;
#(
  parameter  int unsigned FIFO_DEPTH = 8,
  parameter  int unsigned RX_CREDITS = 8,
  localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH)
) (
  input  logic                         clk_wr,
  input  logic                         rst_wr_n,
  lpif_ll_dstrm_tx_master_if.slave     dstrm,
  input  logic                         tx_online,
  input  logic                         m_gen2_mode,
  input  logic                         rx_credit_return,
  output logic [LL_WORD_W-1:0]         txfifo_downstream_data,
  output logic                         user_downstream_vld,
  output logic                         overflow_err,
  output logic                         credit_err
);

  localparam int unsigned CRD_W = $clog2(RX_CREDITS + 1);

  ll_tx_state_e         state_q, state_d;
  logic [3:0]           last_state_q;
  logic                 phase_q;
  logic [CRD_W-1:0]     credit_cnt;
  lpif_ll_word_t        push_word;
  logic [LL_WORD_W-1:0] pop_data;
  logic                 full, empty;
  logic                 is_active, is_flush, send_ok;
  logic                 push_req, push, pop, drop;

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) state_q <= OFFLINE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      OFFLINE: if (tx_online)  state_d = ACTIVE;
      ACTIVE:  if (!tx_online) state_d = FLUSH;
      FLUSH:                   state_d = OFFLINE;
      default:                 state_d = OFFLINE;
    endcase
  end

  always_comb begin
    is_active         = (state_q == ACTIVE);
    is_flush          = (state_q == FLUSH);
    send_ok           = m_gen2_mode || !phase_q;
    dstrm.dstrm_ready = is_active && !full;
    push_req          = dstrm.dstrm_valid || (dstrm.dstrm_state != last_state_q);
    push              = push_req && dstrm.dstrm_ready;
    // Refused pushes only count as errors once the link has come up.
    drop              = push_req && !dstrm.dstrm_ready && (state_q != OFFLINE);
    pop               = is_active && !empty && (credit_cnt != '0) && send_ok;
  end

  always_comb begin
    push_word.valid     = dstrm.dstrm_valid;
    push_word.crc_valid = dstrm.dstrm_crc_valid;
    push_word.crc       = dstrm.dstrm_crc;
    push_word.dvalid    = dstrm.dstrm_dvalid;
    push_word.data      = dstrm.dstrm_data;
    push_word.protid    = dstrm.dstrm_protid;
    push_word.state     = dstrm.dstrm_state;
  end

  lpif_ll_sync_fifo #(
    .WIDTH (LL_WORD_W),
    .DEPTH (FIFO_DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk       (clk_wr),
    .rst_n     (rst_wr_n),
    .flush     (is_flush),
    .push      (push),
    .push_data (push_word),
    .pop       (pop),
    .pop_data  (pop_data),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      last_state_q           <= '0;
      phase_q                <= 1'b0;
      credit_cnt             <= CRD_W'(RX_CREDITS);
      txfifo_downstream_data <= '0;
      user_downstream_vld    <= 1'b0;
      overflow_err           <= 1'b0;
      credit_err             <= 1'b0;
    end else begin
      user_downstream_vld <= pop;
      if (pop)  txfifo_downstream_data <= pop_data;
      if (drop) overflow_err <= 1'b1;
      if (is_flush) begin
        last_state_q <= '0;
        phase_q      <= 1'b0;
        credit_cnt   <= CRD_W'(RX_CREDITS);
      end else begin
        if (push)      last_state_q <= dstrm.dstrm_state;
        if (is_active) phase_q      <= !phase_q;
        if (pop && !rx_credit_return) begin
          credit_cnt <= credit_cnt - CRD_W'(1);
        end else if (rx_credit_return && !pop) begin
          if (credit_cnt == CRD_W'(RX_CREDITS)) credit_err <= 1'b1;
          else                                  credit_cnt <= credit_cnt + CRD_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_lpif_ll_dstrm_tx_master.sv
// Self-checking bench for lpif_ll_dstrm_tx_master: directed scenarios plus randomized traffic
// compared cycle by cycle against a queue-based reference model.
module tb_lpif_ll_dstrm_tx_master;

  localparam int DEPTH = 8;
  localparam int RXC   = 8;

  logic        clk_wr = 1'b0;
  logic        rst_wr_n;
  logic        tx_online, m_gen2_mode, rx_credit_return;
  logic [74:0] tx_data;
  logic        tx_vld, ovf_err, crd_err;

  always #5 clk_wr = ~clk_wr;

  lpif_ll_dstrm_tx_master_if dif ();

  lpif_ll_dstrm_tx_master #(
    .FIFO_DEPTH (DEPTH),
    .RX_CREDITS (RXC)
  ) dut (
    .clk_wr                 (clk_wr),
    .rst_wr_n               (rst_wr_n),
    .dstrm                  (dif),
    .tx_online              (tx_online),
    .m_gen2_mode            (m_gen2_mode),
    .rx_credit_return       (rx_credit_return),
    .txfifo_downstream_data (tx_data),
    .user_downstream_vld    (tx_vld),
    .overflow_err           (ovf_err),
    .credit_err             (crd_err)
  );

  // Reference model: mode 0=link down, 1=running, 2=draining for one cycle.
  int          m_mode;
  logic [74:0] m_q[$];
  int          m_credit;
  logic [3:0]  m_last;
  bit          m_phase;
  logic [74:0] m_data;
  bit          m_vld, m_ovf, m_cerr;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [74:0] pack_word(logic v, logic cv, logic [1:0] c, logic dv,
                                             logic [63:0] d, logic [1:0] p, logic [3:0] s);
    return {v, cv, c, dv, d, p, s};
  endfunction

  function automatic bit m_ready();
    return (m_mode == 1) && (m_q.size() < DEPTH);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_q.delete(); m_credit = RXC; m_last = '0; m_phase = 0;
    m_data = '0; m_vld = 0; m_ovf = 0; m_cerr = 0;
  endtask

  // One clock: evaluate the model from the inputs seen before the edge, then commit after it.
  task automatic cycle();
    bit rdy, preq, pop, on, ret;
    logic [74:0] w;
    logic [3:0]  st;
    rdy  = m_ready();
    st   = dif.dstrm_state;
    preq = dif.dstrm_valid || (st != m_last);
    pop  = (m_mode == 1) && (m_q.size() > 0) && (m_credit > 0) && (m_gen2_mode || !m_phase);
    on   = tx_online;
    ret  = rx_credit_return;
    w    = pack_word(dif.dstrm_valid, dif.dstrm_crc_valid, dif.dstrm_crc, dif.dstrm_dvalid,
                     dif.dstrm_data, dif.dstrm_protid, st);
    @(posedge clk_wr);
    #1;
    m_vld = pop;
    if (pop) m_data = m_q.pop_front();
    if (preq && rdy) begin
      m_q.push_back(w);
      m_last = st;
    end else if (preq && m_mode != 0) begin
      m_ovf = 1;
    end
    if (pop && !ret) m_credit--;
    else if (ret && !pop) begin
      if (m_credit == RXC) m_cerr = 1;
      else                 m_credit++;
    end
    case (m_mode)
      0: if (on) m_mode = 1;
      1: begin m_phase = !m_phase; if (!on) m_mode = 2; end
      default: begin
        m_mode = 0; m_q.delete(); m_credit = RXC; m_last = '0; m_phase = 0;
      end
    endcase
  endtask

  task automatic idle_inputs();
    dif.dstrm_state = '0; dif.dstrm_protid = '0; dif.dstrm_data = '0; dif.dstrm_dvalid = 0;
    dif.dstrm_crc = '0; dif.dstrm_crc_valid = 0; dif.dstrm_valid = 0;
    tx_online = 0; m_gen2_mode = 1; rx_credit_return = 0;
  endtask

  task automatic rand_payload();
    dif.dstrm_data      = {$urandom, $urandom};
    dif.dstrm_protid    = 2'($urandom_range(0, 3));
    dif.dstrm_crc       = 2'($urandom_range(0, 3));
    dif.dstrm_dvalid    = 1'($urandom_range(0, 1));
    dif.dstrm_crc_valid = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset();
    rst_wr_n = 0;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk_wr);
    #1;
    rst_wr_n = 1;
  endtask

  // Bring the link up and spend all credits on throwaway words so later pushes stay queued.
  task automatic go_online_drain();
    tx_online = 1;
    cycle();
    dif.dstrm_valid = 1;
    for (int i = 0; i < RXC; i++) begin rand_payload(); cycle(); end
    dif.dstrm_valid = 0;
    repeat (4) cycle();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (tx_vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld: got %b expected 0", tx_vld); end
    n_checks++; if (tx_data !== 75'd0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", tx_data); end
    n_checks++; if (dif.dstrm_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", dif.dstrm_ready); end
    n_checks++; if ({ovf_err, crd_err} !== 2'b00) begin n_fail++; $display("FAIL reset_errs: got %b expected 00", {ovf_err, crd_err}); end
  endtask

  task automatic test_single_push();
    logic [74:0] exp;
    do_reset();
    tx_online = 1;
    cycle();
    n_checks++; if (dif.dstrm_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %b expected 1", dif.dstrm_ready); end
    dif.dstrm_state = 4'h1; dif.dstrm_protid = 2'd2; dif.dstrm_data = 64'hDEAD_BEEF_0123_4567;
    dif.dstrm_dvalid = 1; dif.dstrm_crc = 2'd1; dif.dstrm_crc_valid = 1; dif.dstrm_valid = 1;
    cycle();
    n_checks++; if (tx_vld !== 1'b0) begin n_fail++; $display("FAIL single_early: got %b expected 0", tx_vld); end
    dif.dstrm_valid = 0;
    cycle();
    exp = {1'b1, 1'b1, 2'd1, 1'b1, 64'hDEAD_BEEF_0123_4567, 2'd2, 4'h1};
    n_checks++; if (tx_vld !== 1'b1) begin n_fail++; $display("FAIL single_vld: got %b expected 1", tx_vld); end
    n_checks++; if (tx_data !== exp) begin n_fail++; $display("FAIL single_data: got %h expected %h", tx_data, exp); end
    cycle();
    n_checks++; if (tx_vld !== 1'b0) begin n_fail++; $display("FAIL single_onepulse: got %b expected 0", tx_vld); end
    n_checks++; if (tx_data !== exp) begin n_fail++; $display("FAIL single_hold: got %h expected %h", tx_data, exp); end
  endtask

  task automatic test_back_to_back();
    int n_out = 0;
    logic [74:0] ninth;
    do_reset();
    tx_online = 1;
    cycle();
    dif.dstrm_valid = 1;
    for (int i = 0; i < 9 + 6; i++) begin
      if (i == 9) dif.dstrm_valid = 0;
      if (i < 9) rand_payload();
      if (i == 8) ninth = pack_word(1'b1, dif.dstrm_crc_valid, dif.dstrm_crc, dif.dstrm_dvalid,
                                    dif.dstrm_data, dif.dstrm_protid, 4'h0);
      cycle();
      if (tx_vld === 1'b1) n_out++;
      n_checks++; if (tx_vld !== m_vld || tx_data !== m_data) begin
        n_fail++; $display("FAIL b2b_cycle%0d: got %b/%h expected %b/%h", i, tx_vld, tx_data, m_vld, m_data);
      end
    end
    n_checks++; if (n_out != 8) begin n_fail++; $display("FAIL b2b_count: got %0d expected 8", n_out); end
    rx_credit_return = 1;
    cycle();
    rx_credit_return = 0;
    n_checks++; if (tx_vld !== 1'b0) begin n_fail++; $display("FAIL b2b_credit_same: got %b expected 0", tx_vld); end
    cycle();
    n_checks++; if (tx_vld !== 1'b1 || tx_data !== ninth) begin
      n_fail++; $display("FAIL b2b_ninth: got %b/%h expected 1/%h", tx_vld, tx_data, ninth);
    end
  endtask

  task automatic test_half_rate();
    logic [6:0] pat = '0;
    int seen = -1;
    int n_out = 0;
    do_reset();
    go_online_drain();
    rx_credit_return = 1;
    repeat (4) cycle();
    rx_credit_return = 0;
    m_gen2_mode = 0;
    dif.dstrm_valid = 1;
    for (int i = 0; i < 16; i++) begin
      if (i == 4) dif.dstrm_valid = 0;
      if (i < 4) rand_payload();
      cycle();
      if (tx_vld === 1'b1) n_out++;
      if (seen < 0 && tx_vld === 1'b1) seen = 0;
      if (seen >= 0 && seen < 7) begin pat = {pat[5:0], tx_vld}; seen++; end
      n_checks++; if (tx_vld !== m_vld || tx_data !== m_data) begin
        n_fail++; $display("FAIL half_cycle%0d: got %b/%h expected %b/%h", i, tx_vld, tx_data, m_vld, m_data);
      end
    end
    n_checks++; if (pat !== 7'b1010101) begin n_fail++; $display("FAIL half_pattern: got %b expected 1010101", pat); end
    n_checks++; if (n_out != 4) begin n_fail++; $display("FAIL half_count: got %0d expected 4", n_out); end
  endtask

  task automatic test_overflow();
    logic [74:0] saved[8];
    int n_out = 0;
    do_reset();
    go_online_drain();
    dif.dstrm_valid = 1;
    for (int i = 0; i < DEPTH; i++) begin
      rand_payload();
      saved[i] = pack_word(1'b1, dif.dstrm_crc_valid, dif.dstrm_crc, dif.dstrm_dvalid,
                           dif.dstrm_data, dif.dstrm_protid, 4'h0);
      n_checks++; if (dif.dstrm_ready !== 1'b1) begin n_fail++; $display("FAIL ovf_fill_ready%0d: got %b expected 1", i, dif.dstrm_ready); end
      cycle();
    end
    n_checks++; if (dif.dstrm_ready !== 1'b0) begin n_fail++; $display("FAIL ovf_full_ready: got %b expected 0", dif.dstrm_ready); end
    n_checks++; if (ovf_err !== 1'b0) begin n_fail++; $display("FAIL ovf_early: got %b expected 0", ovf_err); end
    rand_payload();
    cycle();
    dif.dstrm_valid = 0;
    n_checks++; if (ovf_err !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b expected 1", ovf_err); end
    n_checks++; if (dif.dstrm_ready !== 1'b0) begin n_fail++; $display("FAIL ovf_still_full: got %b expected 0", dif.dstrm_ready); end
    rx_credit_return = 1;
    for (int i = 0; i < 14; i++) begin
      if (i == RXC) rx_credit_return = 0;
      cycle();
      if (tx_vld === 1'b1) begin
        if (n_out < DEPTH) begin
          n_checks++; if (tx_data !== saved[n_out]) begin
            n_fail++; $display("FAIL ovf_word%0d: got %h expected %h", n_out, tx_data, saved[n_out]);
          end
        end
        n_out++;
      end
    end
    n_checks++; if (n_out != DEPTH) begin n_fail++; $display("FAIL ovf_drain_count: got %0d expected 8", n_out); end
    n_checks++; if (ovf_err !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", ovf_err); end
  endtask

  task automatic test_state_change();
    do_reset();
    tx_online = 1;
    cycle();
    rand_payload();
    dif.dstrm_state = 4'h3;
    cycle();
    cycle();
    n_checks++; if (tx_vld !== 1'b1) begin n_fail++; $display("FAIL stchg_vld: got %b expected 1", tx_vld); end
    n_checks++; if (tx_data[74] !== 1'b0 || tx_data[3:0] !== 4'h3) begin
      n_fail++; $display("FAIL stchg_word: got valid=%b state=%h expected valid=0 state=3", tx_data[74], tx_data[3:0]);
    end
    for (int i = 0; i < 5; i++) begin
      cycle();
      n_checks++; if (tx_vld !== 1'b0) begin n_fail++; $display("FAIL stchg_hold%0d: got %b expected 0", i, tx_vld); end
    end
  endtask

  task automatic test_flush();
    logic [74:0] exp;
    do_reset();
    go_online_drain();
    dif.dstrm_valid = 1;
    repeat (3) begin rand_payload(); cycle(); end
    dif.dstrm_valid = 0;
    tx_online = 0;
    cycle();
    n_checks++; if (dif.dstrm_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %b expected 0", dif.dstrm_ready); end
    cycle();
    cycle();
    n_checks++; if (tx_vld !== 1'b0) begin n_fail++; $display("FAIL flush_vld: got %b expected 0", tx_vld); end
    n_checks++; if (crd_err !== 1'b0) begin n_fail++; $display("FAIL flush_cerr_early: got %b expected 0", crd_err); end
    rx_credit_return = 1;
    cycle();
    rx_credit_return = 0;
    n_checks++; if (crd_err !== 1'b1) begin n_fail++; $display("FAIL flush_cerr: got %b expected 1", crd_err); end
    tx_online = 1;
    cycle();
    n_checks++; if (dif.dstrm_ready !== 1'b1) begin n_fail++; $display("FAIL flush_reup_ready: got %b expected 1", dif.dstrm_ready); end
    rand_payload();
    dif.dstrm_valid = 1;
    exp = pack_word(1'b1, dif.dstrm_crc_valid, dif.dstrm_crc, dif.dstrm_dvalid,
                    dif.dstrm_data, dif.dstrm_protid, 4'h0);
    cycle();
    dif.dstrm_valid = 0;
    cycle();
    n_checks++; if (tx_vld !== 1'b1 || tx_data !== exp) begin
      n_fail++; $display("FAIL flush_fresh_word: got %b/%h expected 1/%h", tx_vld, tx_data, exp);
    end
    for (int i = 0; i < 4; i++) begin
      cycle();
      n_checks++; if (tx_vld !== 1'b0) begin n_fail++; $display("FAIL flush_stale%0d: got %b expected 0", i, tx_vld); end
    end
    n_checks++; if (crd_err !== 1'b1) begin n_fail++; $display("FAIL flush_cerr_sticky: got %b expected 1", crd_err); end
  endtask

  task automatic test_async_reset();
    do_reset();
    tx_online = 1;
    cycle();
    dif.dstrm_valid = 1;
    repeat (3) begin rand_payload(); cycle(); end
    rx_credit_return = 1;
    cycle();
    dif.dstrm_valid = 0;
    rx_credit_return = 0;
    #2;
    rst_wr_n = 0;
    #1;
    n_checks++; if (tx_vld !== 1'b0 || tx_data !== 75'd0) begin
      n_fail++; $display("FAIL areset_out: got %b/%h expected 0/0", tx_vld, tx_data);
    end
    n_checks++; if (dif.dstrm_ready !== 1'b0) begin n_fail++; $display("FAIL areset_ready: got %b expected 0", dif.dstrm_ready); end
    do_reset();
    tx_online = 1;
    repeat (4) cycle();
    n_checks++; if (tx_vld !== 1'b0) begin n_fail++; $display("FAIL areset_lost: got %b expected 0", tx_vld); end
  endtask

  task automatic test_random();
    do_reset();
    tx_online = 1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) < 2) tx_online = !tx_online;
      if ($urandom_range(0, 99) < 5) m_gen2_mode = !m_gen2_mode;
      rand_payload();
      dif.dstrm_valid = ($urandom_range(0, 99) < 60);
      if ($urandom_range(0, 99) < 10) dif.dstrm_state = 4'($urandom_range(0, 15));
      rx_credit_return = 0;
      if (m_mode != 2) begin
        if ((RXC - m_credit) > 0 && $urandom_range(0, 99) < 40) rx_credit_return = 1;
        else if ($urandom_range(0, 999) < 5) rx_credit_return = 1;
      end
      cycle();
      n_checks++; if (tx_vld !== m_vld || tx_data !== m_data) begin
        n_fail++; $display("FAIL rand_out%0d: got %b/%h expected %b/%h", i, tx_vld, tx_data, m_vld, m_data);
      end
      n_checks++; if (dif.dstrm_ready !== m_ready()) begin
        n_fail++; $display("FAIL rand_ready%0d: got %b expected %b", i, dif.dstrm_ready, m_ready());
      end
      n_checks++; if (ovf_err !== m_ovf || crd_err !== m_cerr) begin
        n_fail++; $display("FAIL rand_errs%0d: got %b%b expected %b%b", i, ovf_err, crd_err, m_ovf, m_cerr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_back_to_back();
    test_half_rate();
    test_overflow();
    test_state_change();
    test_flush();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
